mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the core's single external memory port between instruction fetch (IF) and the
//  load/store in the MEM stage (fed by execute_to_memory). Grants one requester at a time,
//  drives a req/ack bus, returns read data, generates StallF/StallM until each access
//  completes, and aborts hung accesses with a watchdog.
// PARAMETERS
//  TIMEOUT_CYCLES  255  cycles in a grant state without bus_ack before abort (>=1, <=65535)
// PORTS
//  clk          in   1   clock; all logic on posedge
//  reset        in   1   synchronous, active-high; clears all state
//  if_req       in   1   fetch wants instruction at if_addr
//  if_addr      in   32  fetch address
//  if_rdata     out  32  fetched instruction; valid while if_done=1
//  if_done      out  1   one-cycle pulse: fetch complete
//  StallF       out  1   hold fetch stage
//  mem_read     in   1   MEM-stage load (result_src_o==2'b01)
//  mem_write    in   4   MEM-stage store byte enables; nonzero = store
//  mem_addr     in   32  alu_result_o from EX/MEM register
//  mem_wdata    in   32  write_data_o from EX/MEM register
//  mem_rdata    out  32  load data; valid while mem_done=1
//  mem_done     out  1   one-cycle pulse: MEM access complete
//  StallM       out  1   hold EX/MEM register and upstream
//  bus_req      out  1   bus request, registered
//  bus_we       out  4   byte write enables, 0 = read, registered
//  bus_addr     out  32  registered, stable while bus_req=1
//  bus_wdata    out  32  registered, stable while bus_req=1
//  bus_ack      in   1   access done; bus_rdata valid same cycle; ignored when bus_req=0
//  bus_rdata    in   32  read data
//  err          out  1   sticky: watchdog abort occurred
// BEHAVIOUR
//  Reset: state=IDLE; bus_req, bus_we, bus_addr, bus_wdata, if_rdata, mem_rdata, if_done,
//   mem_done, err, watchdog counter, last_grant all 0. Reset mid-access drops bus_req at
//   that edge; no completion pulse is produced.
//  mem_access = mem_read | (mem_write!=0). If both are set, mem_write wins (store).
//  States: IDLE, GNT_IF, GNT_MEM.
//   IDLE: if mem_access & ~mem_done & if_req & ~if_done -> pick the requester not in
//    last_grant; else the single pending requester. No request -> stay.
//    On grant: latch addr/we/wdata (we=0 for fetch), bus_req<=1, last_grant<=winner.
//   GNT_x: bus_ack=1 -> bus_req<=0, latch bus_rdata into x_rdata, x_done<=1, go IDLE.
//    No ack -> counter++. Counter==TIMEOUT_CYCLES-1 without ack -> abort: bus_req<=0,
//    x_rdata<=0, x_done<=1, err<=1, go IDLE. Counter clears on grant entry.
//  Done pulses: exactly 1 cycle, cleared at the next edge. The IDLE pending check uses the
//   done term, so the same access is not reissued while its pulse is high.
//  StallM = mem_access & ~mem_done (combinational). StallF = if_req & ~if_done.
//  Latency: request at cycle t (IDLE, no contention) -> bus_req at t+1. Ack at t+1 ->
//   done at t+2. Stall is high on t and t+1 and low on t+2. Minimum 2 cycles.
//  Back-to-back: a new MEM instruction arriving at t+3 is treated as a new request.
//   No grant happens in the done cycle itself.
//  bus_addr/bus_we/bus_wdata hold their last values when bus_req=0.
//  Watchdog counter is 16 bits.
// TESTING
//  1 Lone load: mem_read=1, addr=0x100, ack after 3 cycles with 0xCAFEF00D ->
//    bus_we=0, mem_rdata=0xCAFEF00D with mem_done for 1 cycle, StallM low exactly then.
//  2 Store: mem_write=4'b0011, addr=0x204, wdata=0x12345678, immediate ack ->
//    bus_we=0011 with addr/wdata stable until ack, StallM high for 2 cycles.
//  3 Contention: if_req and mem_read both rising in IDLE with last_grant=IF -> MEM granted
//    first, then IF. Repeat with last_grant=MEM -> IF granted first. No bus gap beyond 1
//    IDLE cycle.
//  4 Timeout: TIMEOUT_CYCLES=4, no ack -> bus_req drops after 4 grant cycles,
//    mem_rdata=0, mem_done pulses, err=1 and stays 1 until reset.
//  5 Reset while GNT_MEM and bus_req=1 -> next cycle bus_req=0, all outputs 0, state IDLE.
//  6 Spurious bus_ack while bus_req=0 -> ignored; no done pulse, state unchanged.

Source files
------------

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter
// Shares one req/ack memory port between instruction fetch and the MEM stage,
// with round-robin tie-break, stall generation and a per-access watchdog.
// Revision: 1.0
// ============================================================================
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_done,
  output logic        StallF,
  input  logic        mem_read,
  input  logic [3:0]  mem_write,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_done,
  output logic        StallM,
  output logic        bus_req,
  output logic [3:0]  bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        err
);

  localparam logic [1:0]  S_IDLE       = 2'd0;
  localparam logic [1:0]  S_GNT_IF     = 2'd1;
  localparam logic [1:0]  S_GNT_MEM    = 2'd2;
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic        bus_req_q, bus_req_d;
  logic [3:0]  bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;
  logic        if_done_q, if_done_d;
  logic        mem_done_q, mem_done_d;
  logic        err_q, err_d;
  logic [15:0] wd_cnt_q, wd_cnt_d;
  logic        last_mem_q, last_mem_d;

  logic        mem_access;
  logic        mem_pending;
  logic        if_pending;
  logic        grant_mem;
  logic        grant_if;
  logic        timeout;
  logic        finish;
  logic [31:0] finish_data;

  // A requester whose done pulse is high has already been served this access.
  assign mem_access  = mem_read | (mem_write != 4'h0);
  assign mem_pending = mem_access & ~mem_done_q;
  assign if_pending  = if_req & ~if_done_q;
  assign grant_mem   = mem_pending & (~if_pending | ~last_mem_q);
  assign grant_if    = if_pending & ~grant_mem;
  assign timeout     = (wd_cnt_q == TIMEOUT_LAST);
  assign finish      = bus_ack | timeout;
  assign finish_data = bus_ack ? bus_rdata : 32'h0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 4'h0;
      bus_addr_q  <= 32'h0;
      bus_wdata_q <= 32'h0;
      if_rdata_q  <= 32'h0;
      mem_rdata_q <= 32'h0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      err_q       <= 1'b0;
      wd_cnt_q    <= 16'h0;
      last_mem_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
      err_q       <= err_d;
      wd_cnt_q    <= wd_cnt_d;
      last_mem_q  <= last_mem_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (grant_mem) begin
          state_d = S_GNT_MEM;
        end else if (grant_if) begin
          state_d = S_GNT_IF;
        end
      end
      S_GNT_IF, S_GNT_MEM: begin
        if (finish) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
    err_d       = err_q;
    wd_cnt_d    = wd_cnt_q;
    last_mem_d  = last_mem_q;
    case (state_q)
      S_IDLE: begin
        if (grant_mem) begin
          bus_req_d   = 1'b1;
          bus_we_d    = mem_write;
          bus_addr_d  = mem_addr;
          bus_wdata_d = mem_wdata;
          wd_cnt_d    = 16'h0;
          last_mem_d  = 1'b1;
        end else if (grant_if) begin
          bus_req_d  = 1'b1;
          bus_we_d   = 4'h0;
          bus_addr_d = if_addr;
          wd_cnt_d   = 16'h0;
          last_mem_d = 1'b0;
        end
      end
      S_GNT_IF, S_GNT_MEM: begin
        if (finish) begin
          bus_req_d = 1'b0;
          err_d     = err_q | ~bus_ack;
          if (state_q == S_GNT_MEM) begin
            mem_rdata_d = finish_data;
            mem_done_d  = 1'b1;
          end else begin
            if_rdata_d = finish_data;
            if_done_d  = 1'b1;
          end
        end else begin
          wd_cnt_d = wd_cnt_q + 16'd1;
        end
      end
      default: ;
    endcase
  end

  assign StallM    = mem_access & ~mem_done_q;
  assign StallF    = if_req & ~if_done_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign mem_rdata = mem_rdata_q;
  assign if_done   = if_done_q;
  assign mem_done  = mem_done_q;
  assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_port_arbiter
// Directed bench with a transaction-level reference model of the arbiter.
// Revision: 1.0
// ============================================================================
module tb_mem_port_arbiter;

  localparam int unsigned TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        StallF;
  logic        mem_read;
  logic [3:0]  mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_done;
  logic        StallM;
  logic        bus_req;
  logic [3:0]  bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = 32'h0;
  logic        err;

  always #5 clk = ~clk;

  mem_port_arbiter #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done), .StallF(StallF),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done), .StallM(StallM),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata), .err(err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Bus slave: acks in the (resp_delay+1)-th cycle of a request; -1 never acks.
  int          resp_delay = -1;
  logic [31:0] resp_data  = 32'h0;
  logic        spurious   = 1'b0;
  int          gcnt       = 0;

  always @(posedge clk) begin
    #1;
    if (bus_req) begin
      if (resp_delay >= 0 && gcnt == resp_delay) begin
        bus_ack   = 1'b1;
        bus_rdata = resp_data;
      end else begin
        bus_ack   = 1'b0;
        bus_rdata = 32'hBAD0_0000 | 32'(gcnt);
      end
      gcnt = gcnt + 1;
    end else begin
      gcnt      = 0;
      bus_ack   = spurious;
      bus_rdata = 32'h5A5A_5A5A;
    end
  end

  // Reference model: owner 0 = none, 1 = fetch, 2 = MEM; age = grant cycles so far.
  bit          m_valid = 1'b0;
  int          m_owner, m_age;
  bit          m_last_mem;
  logic [31:0] m_addr, m_wdata, m_if_rdata, m_mem_rdata;
  logic [3:0]  m_we;
  bit          m_if_done, m_mem_done, m_err;

  always @(posedge clk) begin
    bit want_mem, want_if, nd_if, nd_mem;
    int win;
    m_valid = 1'b1;
    if (reset) begin
      m_owner = 0; m_age = 0; m_last_mem = 1'b0;
      m_addr = 32'h0; m_wdata = 32'h0; m_we = 4'h0;
      m_if_rdata = 32'h0; m_mem_rdata = 32'h0;
      m_if_done = 1'b0; m_mem_done = 1'b0; m_err = 1'b0;
    end else begin
      nd_if = 1'b0;
      nd_mem = 1'b0;
      if (m_owner == 0) begin
        want_mem = (mem_read || mem_write != 4'h0) && !m_mem_done;
        want_if  = if_req && !m_if_done;
        win = 0;
        if (want_mem && want_if) win = m_last_mem ? 1 : 2;
        else if (want_mem)       win = 2;
        else if (want_if)        win = 1;
        if (win == 2) begin
          m_addr = mem_addr; m_we = mem_write; m_wdata = mem_wdata;
        end else if (win == 1) begin
          m_addr = if_addr; m_we = 4'h0;
        end
        if (win != 0) begin
          m_owner = win; m_age = 1; m_last_mem = (win == 2);
        end
      end else if (bus_ack) begin
        if (m_owner == 2) begin m_mem_rdata = bus_rdata; nd_mem = 1'b1; end
        else begin m_if_rdata = bus_rdata; nd_if = 1'b1; end
        m_owner = 0;
      end else if (m_age == int'(TIMEOUT)) begin
        if (m_owner == 2) begin m_mem_rdata = 32'h0; nd_mem = 1'b1; end
        else begin m_if_rdata = 32'h0; nd_if = 1'b1; end
        m_err = 1'b1;
        m_owner = 0;
      end else begin
        m_age = m_age + 1;
      end
      m_if_done = nd_if;
      m_mem_done = nd_mem;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  logic s_bus_req, s_mem_done, s_if_done, s_stallm, s_stallf;

  // One clock: sample and compare against the model at negedge, then let a
  // requester drop its request once it has seen its done pulse.
  task automatic step();
    @(negedge clk);
    s_bus_req = bus_req; s_mem_done = mem_done; s_if_done = if_done;
    s_stallm = StallM; s_stallf = StallF;
    if (m_valid) begin
      check("m.bus_req",   32'(bus_req),   32'(m_owner != 0));
      check("m.bus_addr",  bus_addr,       m_addr);
      check("m.bus_we",    32'(bus_we),    32'(m_we));
      if (m_we != 4'h0) check("m.bus_wdata", bus_wdata, m_wdata);
      check("m.if_rdata",  if_rdata,       m_if_rdata);
      check("m.mem_rdata", mem_rdata,      m_mem_rdata);
      check("m.if_done",   32'(if_done),   32'(m_if_done));
      check("m.mem_done",  32'(mem_done),  32'(m_mem_done));
      check("m.err",       32'(err),       32'(m_err));
      check("m.StallF",    32'(StallF),    32'(if_req && !m_if_done));
      check("m.StallM",    32'(StallM),    32'((mem_read || mem_write != 4'h0) && !m_mem_done));
    end
    #1;
    if (mem_done) begin mem_read = 1'b0; mem_write = 4'h0; end
    if (if_done) if_req = 1'b0;
  endtask

  task automatic wait_done(input bit want_mem, input int maxc, output int req_n, output int stall_n);
    req_n = 0;
    stall_n = 0;
    for (int i = 0; i < maxc; i++) begin
      step();
      if (want_mem ? s_mem_done : s_if_done) return;
      req_n += int'(s_bus_req);
      stall_n += int'(want_mem ? s_stallm : s_stallf);
    end
    n_checks++;
    n_fail++;
    $display("FAIL wait_done: no done pulse within %0d cycles", maxc);
  endtask

  initial begin
    int rq, st;
    reset = 1'b1; if_req = 1'b0; if_addr = 32'h0;
    mem_read = 1'b0; mem_write = 4'h0; mem_addr = 32'h0; mem_wdata = 32'h0;
    repeat (3) step();
    check("rst.bus_req",   32'(bus_req),   32'h0);
    check("rst.bus_addr",  bus_addr,       32'h0);
    check("rst.bus_we",    32'(bus_we),    32'h0);
    check("rst.bus_wdata", bus_wdata,      32'h0);
    check("rst.mem_rdata", mem_rdata,      32'h0);
    check("rst.if_rdata",  if_rdata,       32'h0);
    check("rst.done",      32'({if_done, mem_done}), 32'h0);
    check("rst.err",       32'(err),       32'h0);
    reset = 1'b0;
    step();

    // Lone load, ack in the third grant cycle
    resp_delay = 2; resp_data = 32'hCAFE_F00D;
    mem_read = 1'b1; mem_addr = 32'h100; mem_wdata = 32'hFFFF_FFFF;
    #1 check("load.stall_req_cycle", 32'(StallM), 32'h1);
    wait_done(1'b1, 20, rq, st);
    check("load.req_cycles", 32'(rq), 32'd3);
    check("load.stall_cycles", 32'(st), 32'd3);
    check("load.stall_at_done", 32'(s_stallm), 32'h0);
    check("load.rdata", mem_rdata, 32'hCAFE_F00D);
    check("load.bus_we", 32'(bus_we), 32'h0);
    check("load.bus_addr", bus_addr, 32'h100);
    step();
    check("load.done_one_cycle", 32'(s_mem_done), 32'h0);

    // Store, immediate ack
    resp_delay = 0;
    mem_write = 4'b0011; mem_addr = 32'h204; mem_wdata = 32'h1234_5678;
    #1 check("store.stall_req_cycle", 32'(StallM), 32'h1);
    wait_done(1'b1, 20, rq, st);
    check("store.req_cycles", 32'(rq), 32'd1);
    check("store.stall_cycles", 32'(st), 32'd1);
    check("store.bus_we", 32'(bus_we), 32'h3);
    check("store.bus_addr", bus_addr, 32'h204);
    check("store.bus_wdata", bus_wdata, 32'h1234_5678);
    step();

    // Lone fetch leaves last grant = fetch
    resp_delay = 1; resp_data = 32'h0000_0013;
    if_req = 1'b1; if_addr = 32'h40;
    wait_done(1'b0, 20, rq, st);
    check("fetch.req_cycles", 32'(rq), 32'd2);
    check("fetch.rdata", if_rdata, 32'h0000_0013);
    step();

    // Contention after a fetch: MEM first, one idle cycle, then fetch
    resp_delay = 0; resp_data = 32'h1111_1111;
    if_req = 1'b1; if_addr = 32'h44; mem_read = 1'b1; mem_addr = 32'h300;
    step();
    check("contA.first_req", 32'(s_bus_req), 32'h1);
    check("contA.first_addr", bus_addr, 32'h300);
    step();
    check("contA.mem_done", 32'(s_mem_done), 32'h1);
    check("contA.gap", 32'(s_bus_req), 32'h0);
    step();
    check("contA.second_req", 32'(s_bus_req), 32'h1);
    check("contA.second_addr", bus_addr, 32'h44);
    step();
    check("contA.if_done", 32'(s_if_done), 32'h1);
    check("contA.if_rdata", if_rdata, 32'h1111_1111);
    step();

    // Lone load leaves last grant = MEM, then contention: fetch first
    resp_data = 32'h2222_2222;
    mem_read = 1'b1; mem_addr = 32'h310;
    wait_done(1'b1, 20, rq, st);
    step();
    resp_data = 32'h3333_3333;
    if_req = 1'b1; if_addr = 32'h48; mem_read = 1'b1; mem_addr = 32'h320;
    step();
    check("contB.first_addr", bus_addr, 32'h48);
    step();
    check("contB.if_done", 32'(s_if_done), 32'h1);
    step();
    check("contB.second_req", 32'(s_bus_req), 32'h1);
    check("contB.second_addr", bus_addr, 32'h320);
    step();
    check("contB.mem_done", 32'(s_mem_done), 32'h1);
    step();

    // Watchdog abort on a hung load
    resp_delay = -1;
    mem_read = 1'b1; mem_addr = 32'h500;
    wait_done(1'b1, 20, rq, st);
    check("timeout.req_cycles", 32'(rq), 32'd4);
    check("timeout.rdata", mem_rdata, 32'h0);
    check("timeout.err", 32'(err), 32'h1);
    step();
    resp_delay = 0; resp_data = 32'h0000_0077;
    mem_read = 1'b1; mem_addr = 32'h504;
    wait_done(1'b1, 20, rq, st);
    check("timeout.recover_rdata", mem_rdata, 32'h0000_0077);
    check("timeout.err_sticky", 32'(err), 32'h1);
    step();

    // Spurious ack while idle
    spurious = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("spur.no_done", 32'({s_if_done, s_mem_done}), 32'h0);
      check("spur.no_req", 32'(s_bus_req), 32'h0);
    end
    check("spur.rdata_kept", mem_rdata, 32'h0000_0077);
    spurious = 1'b0;
    step();

    // Reset in the middle of a MEM grant
    resp_delay = -1;
    mem_write = 4'hF; mem_addr = 32'h600; mem_wdata = 32'h55AA_55AA;
    step();
    check("rstmid.req", 32'(s_bus_req), 32'h1);
    check("rstmid.we", 32'(bus_we), 32'hF);
    step();
    reset = 1'b1;
    step();
    check("rstmid.bus_req", 32'(bus_req), 32'h0);
    check("rstmid.bus_addr", bus_addr, 32'h0);
    check("rstmid.bus_we", 32'(bus_we), 32'h0);
    check("rstmid.bus_wdata", bus_wdata, 32'h0);
    check("rstmid.mem_rdata", mem_rdata, 32'h0);
    check("rstmid.err", 32'(err), 32'h0);
    reset = 1'b0;
    mem_write = 4'h0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rstmid.no_done", 32'(s_mem_done), 32'h0);
      check("rstmid.idle", 32'(s_bus_req), 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
